// File: rtl/multi_trig_seq.sv
// -----------------------------------------------------------------------------
// multi_trig_seq
//   Multi-channel trigger sequencer. Trigger events come from an internal
//   period counter or from a synchronized external pin. Each accepted event
//   waits a programmable delay and then drives a programmable-width pulse on
//   one channel. Channels are chosen round-robin among the enabled mask bits.
//
// Ports
//   i_clk       sole clock
//   i_rst       asynchronous active-high reset
//   i_en        run enable; low forces IDLE and holds the round-robin pointer
//   i_outmode   1 = external trigger pin, 0 = internal period counter
//   i_negedge   external edge select, 1 = falling
//   i_ext_trig  asynchronous external trigger pin
//   i_cycle     internal period in clocks (0 = no internal events)
//   i_delay     event-to-pulse delay in clocks
//   i_pulse     pulse width in clocks (0 = no pulse, pointer still advances)
//   i_ch_mask   channel enable mask
//   o_trig      one-hot (or zero) trigger pulses
//   o_ch        channel currently or last fired
//   o_fire      one-clock strobe on the first clock of each pulse
//   o_busy      high while in DELAY or PULSE
//   o_missed    one-clock strobe when an event is dropped
//   o_pat       test pattern
//
// Configuration
//   MULTI_TRIG_SEQ_TEST_PATTERN_EN : when defined, o_pat counts 0..PAT_MAX and
//   restarts at 0 on the clock after o_fire; otherwise o_pat is tied to 0.
// -----------------------------------------------------------------------------
module multi_trig_seq #(
  parameter int CH_NUM  = 4,
  parameter int CYCLE_W = 20,
  parameter int DLY_W   = 16,
  parameter int PULSE_W = 12,
  parameter int PAT_W   = 8,
  parameter int PAT_MAX = 199,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_outmode,
  input  logic               i_negedge,
  input  logic               i_ext_trig,
  input  logic [CYCLE_W-1:0] i_cycle,
  input  logic [DLY_W-1:0]   i_delay,
  input  logic [PULSE_W-1:0] i_pulse,
  input  logic [CH_NUM-1:0]  i_ch_mask,
  output logic [CH_NUM-1:0]  o_trig,
  output logic [CH_W-1:0]    o_ch,
  output logic               o_fire,
  output logic               o_busy,
  output logic               o_missed,
  output logic [PAT_W-1:0]   o_pat
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_t;

  state_t               r_state;
  logic [CYCLE_W-1:0]   r_cnt;
  logic                 r_sync1, r_sync2, r_sync3;
  logic [DLY_W-1:0]     r_dcnt, r_lat_dly;
  logic [PULSE_W-1:0]   r_pcnt, r_lat_pulse;
  logic [CH_W-1:0]      r_ptr, r_ch;
  logic [CH_NUM-1:0]    r_trig;
  logic                 r_fire, r_busy, r_missed;

  logic                 w_int_run, w_int_wrap, w_ext_evt, w_evt;
  logic [2*CH_NUM-1:0]  w_dbl;
  logic [CH_W-1:0]      w_off;
  logic [CH_W:0]        w_sum;
  logic [CH_W-1:0]      w_sel;

  // Internal period: count 0..i_cycle-1, event on the wrap clock. The >=
  // compare recovers cleanly if i_cycle shrinks below the running count.
  assign w_int_run  = i_en & ~i_outmode & (i_cycle != '0);
  assign w_int_wrap = w_int_run & (r_cnt >= i_cycle - CYCLE_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers; blocking here would create races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            r_cnt <= '0;
    else if (!w_int_run)  r_cnt <= '0;
    else if (w_int_wrap)  r_cnt <= '0;
    else                  r_cnt <= r_cnt + CYCLE_W'(1);
  end

  // Two-flop synchronizer plus edge register: an event is seen on the third
  // edge after the pin transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_ext_trig;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_ext_evt = i_en & i_outmode &
                     (i_negedge ? (~r_sync2 & r_sync3) : (r_sync2 & ~r_sync3));
  assign w_evt     = w_int_wrap | w_ext_evt;

  // Round-robin select: rotate the mask so the pointer sits at bit 0, find the
  // lowest set bit, then add the pointer back modulo CH_NUM.
  assign w_dbl = {i_ch_mask, i_ch_mask} >> r_ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_off = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (w_dbl[i]) w_off = CH_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (CH_W+1)'(CH_NUM)) w_sum = w_sum - (CH_W+1)'(CH_NUM);
    w_sel = w_sum[CH_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_dcnt      <= '0;
      r_pcnt      <= '0;
      r_lat_dly   <= '0;
      r_lat_pulse <= '0;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_trig      <= '0;
      r_fire      <= 1'b0;
      r_busy      <= 1'b0;
      r_missed    <= 1'b0;
    end else begin
      r_fire   <= 1'b0;
      r_missed <= 1'b0;
      if (!i_en) begin
        // Abort: events this clock are ignored silently, pointer held.
        r_state <= S_IDLE;
        r_trig  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_evt) begin
              if (|i_ch_mask) begin
                r_lat_dly   <= i_delay;
                r_lat_pulse <= i_pulse;
                r_ch        <= w_sel;
                r_dcnt      <= '0;
                r_pcnt      <= '0;
                r_busy      <= 1'b1;
                r_state     <= (i_delay == '0) ? S_PULSE : S_DELAY;
              end else begin
                r_missed <= 1'b1;
              end
            end
          end
          S_DELAY: begin
            if (w_evt) r_missed <= 1'b1;
            if (r_dcnt == r_lat_dly - DLY_W'(1)) r_state <= S_PULSE;
            else                                 r_dcnt  <= r_dcnt + DLY_W'(1);
          end
          S_PULSE: begin
            if (w_evt) r_missed <= 1'b1;
            // The state leads o_trig by one clock, so a pulse of p occupies
            // p+1 PULSE clocks; the last one drops o_trig and advances.
            if (r_pcnt < r_lat_pulse) begin
              r_trig <= CH_NUM'(1) << r_ch;
              r_fire <= (r_pcnt == '0);
              r_pcnt <= r_pcnt + PULSE_W'(1);
            end else begin
              r_trig  <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_ptr   <= (r_ch == CH_W'(CH_NUM - 1)) ? '0 : r_ch + CH_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_trig  <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_trig   = r_trig;
  assign o_ch     = r_ch;
  assign o_fire   = r_fire;
  assign o_busy   = r_busy;
  assign o_missed = r_missed;

`ifdef MULTI_TRIG_SEQ_TEST_PATTERN_EN
  logic [PAT_W-1:0] r_pat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           r_pat <= '0;
    else if (r_fire)                     r_pat <= '0;
    else if (r_pat == PAT_W'(PAT_MAX))   r_pat <= '0;
    else                                 r_pat <= r_pat + PAT_W'(1);
  end

  assign o_pat = r_pat;
`else
  assign o_pat = '0;
`endif

endmodule
